// File: rtl/data_mem_unit.sv
// Multi-cycle data-memory responder: sized/sign-extended loads and byte-masked stores,
// completing a fixed LATENCY edges after a request is accepted.
module data_mem_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                op_wr_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         mem [Depth];

  logic                req, req_ok, access;
  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic [3:0]          be;
  logic [31:0]         wword, rword, shifted, ld_data;

  // High address bits alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign req      = MemRead | MemWrite;
  assign access   = (state_q == StWait) && (cnt_q == 4'd0);
  assign word_idx = addr_q[ADDR_W+1:2];
  assign lane     = addr_q[1:0];

  always_comb begin
    req_ok = 1'b1;
    if (MemRead && MemWrite) req_ok = 1'b0;
    if (MemRead) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ;
        default: req_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: ;
        default: req_ok = 1'b0;
      endcase
    end
    if (funct3[1:0] == 2'b01 && addr[0]) req_ok = 1'b0;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) req_ok = 1'b0;
  end

  // Store data is replicated across lanes so the byte enable alone selects the target.
  always_comb begin
    be    = 4'b1111;
    wword = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_q;
      end
    endcase
  end

  always_comb begin
    rword   = mem[word_idx];
    shifted = rword >> {lane, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = rword;
    endcase
  end

  // No reset on the array: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (access && op_wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata   <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            if (req_ok) begin
              op_wr_q <= MemWrite;
              f3_q    <= funct3;
              addr_q  <= addr[ADDR_W+1:0];
              wdata_q <= wdata;
              cnt_q   <= 4'(LATENCY - 1);
              busy    <= 1'b1;
              state_q <= StWait;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            if (!op_wr_q) rdata <= ld_data;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed scenarios then random traffic against a byte-array model.
module tb_data_mem_unit;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mdl [4096];
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  data_mem_unit #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a);
    int nb;
    if (rd && wr) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    nb = 1 << f3[1:0];
    return (a % nb) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int nb, base;
    logic [31:0] v;
    nb   = 1 << f3[1:0];
    base = int'(a % 4096);
    v    = 32'd0;
    for (int i = 0; i < nb; i++) v |= 32'(mdl[base + i]) << (8 * i);
    if (!f3[2] && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int nb, base;
    nb   = 1 << f3[1:0];
    base = int'(a % 4096);
    for (int i = 0; i < nb; i++) mdl[base + i] = wd[8*i +: 8];
  endtask

  task automatic noise_drive();
    MemRead  = 1'($urandom_range(0, 1));
    MemWrite = 1'($urandom_range(0, 1));
    funct3   = 3'($urandom_range(0, 7));
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit noise);
    bit ok;
    ok = legal(rd, wr, f3, a);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    if (!ok) begin
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      chk("rej_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("rej_err_clear", 32'(err), 32'd0);
      chk("rej_rdata", rdata, exp_rdata);
      return;
    end
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_err", 32'(err), 32'd0);
    chk("acc_done", 32'(done), 32'd0);
    for (int i = 1; i < int'(LAT); i++) begin
      if (noise) noise_drive();
      @(posedge clk); #1;
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_done", 32'(done), 32'd0);
      chk("wait_err", 32'(err), 32'd0);
    end
    if (noise) noise_drive();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("cmp_done", 32'(done), 32'd1);
    chk("cmp_busy", 32'(busy), 32'd0);
    chk("cmp_err", 32'(err), 32'd0);
    if (wr) model_store(f3, a, wd);
    else exp_rdata = model_load(f3, a);
    chk(wr ? "st_rdata_hold" : "ld_rdata", rdata, exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) access(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0);

    // Basic word store/load and sized loads.
    access(1'b0, 1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h8, 32'd0, 1'b0);
    chk("t1_lw", rdata, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 3'd0, 32'hB, 32'd0, 1'b0); chk("t2_lb", rdata, 32'hFFFF_FFDE);
    access(1'b1, 1'b0, 3'd4, 32'hB, 32'd0, 1'b0); chk("t2_lbu", rdata, 32'h0000_00DE);
    access(1'b1, 1'b0, 3'd1, 32'hA, 32'd0, 1'b0); chk("t2_lh", rdata, 32'hFFFF_DEAD);
    access(1'b1, 1'b0, 3'd5, 32'hA, 32'd0, 1'b0); chk("t2_lhu", rdata, 32'h0000_DEAD);
    access(1'b1, 1'b0, 3'd0, 32'h8, 32'd0, 1'b0); chk("t2_lb0", rdata, 32'hFFFF_FFEF);

    // Partial stores preserve the other lanes.
    access(1'b0, 1'b1, 3'd0, 32'h9, 32'h1234_5655, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h8, 32'd0, 1'b0); chk("t3_sb", rdata, 32'hDEAD_55EF);
    access(1'b0, 1'b1, 3'd1, 32'hA, 32'h0000_BEEF, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h8, 32'd0, 1'b0); chk("t3_sh", rdata, 32'hBEEF_55EF);

    // Rejected requests.
    access(1'b1, 1'b0, 3'd2, 32'h6, 32'd0, 1'b0);
    access(1'b0, 1'b1, 3'd1, 32'h3, 32'hFFFF_FFFF, 1'b0);
    access(1'b1, 1'b0, 3'd3, 32'h8, 32'd0, 1'b0);
    access(1'b1, 1'b1, 3'd2, 32'h8, 32'h0, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h8, 32'd0, 1'b0); chk("t4_unchanged", rdata, 32'hBEEF_55EF);

    // Reset abandons an in-flight store.
    access(1'b0, 1'b1, 3'd2, 32'h10, 32'h1111_1111, 1'b0);
    @(negedge clk);
    MemWrite = 1'b1; funct3 = 3'd2; addr = 32'h10; wdata = 32'h2222_2222;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    chk("t5_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_done", 32'(done), 32'd0);
    chk("t5_async_rdata", rdata, 32'd0);
    exp_rdata = 32'd0;
    @(posedge clk); #1;
    chk("t5_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0); chk("t5_lw", rdata, 32'h1111_1111);

    // Aliasing and requests ignored while busy.
    access(1'b0, 1'b1, 3'd2, 32'h1008, 32'hCAFE_F00D, 1'b1);
    access(1'b1, 1'b0, 3'd2, 32'h8, 32'd0, 1'b1); chk("t6_wrap", rdata, 32'hCAFE_F00D);

    for (int n = 0; n < 200; n++) begin
      int kind;
      logic rd, wr;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rd   = (kind < 5) || (kind == 9);
      wr   = (kind >= 5);
      a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) << 2)
             | 32'($urandom_range(0, 3));
      access(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    chk("end_done_clear", 32'(done), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
